// File: rtl/mesh_pkg.sv
// Shared types and helpers for the shear-sort mesh: sequencer states, operation
// modes and the total sort-phase cycle count.
package mesh_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ROW,
    S_COL,
    S_DELIVER,
    S_DONE
  } state_e;

  localparam int unsigned MODE_WRITE = 0;
  localparam int unsigned MODE_READ  = 1;

  // Cycles spent in ROW and COL phases: ROUNDS row phases interleaved with ROUNDS-1 column phases
  function automatic int unsigned sort_cycles(input int unsigned side,
                                              input int unsigned rounds,
                                              input int unsigned step_cycles);
    return (2 * rounds - 1) * side * step_cycles;
  endfunction

endpackage

// File: rtl/mesh_step_cnt.sv
// Modulo-N up-counter with synchronous clear, enable and terminal-count flag;
// wraps to zero on the enabled cycle after reaching MODULUS-1.
module mesh_step_cnt #(
  parameter  int unsigned MODULUS = 4,
  localparam int unsigned W       = (MODULUS > 1) ? $clog2(MODULUS) : 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         last_c
);

  assign last_c = (count == W'(MODULUS - 1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= last_c ? '0 : count + W'(1);
    end
  end

endmodule

// File: rtl/mesh_sort_sched.sv
// Shear-sort phase sequencer: walks ROUNDS row phases interleaved with column
// phases, broadcasting phase/parity/snake to the PE array, then strobes deliver.
module mesh_sort_sched
  import mesh_pkg::*;
#(
  parameter  int unsigned SIDE        = 16,
  parameter  int unsigned ROUNDS      = $clog2(SIDE) + 1,
  parameter  int unsigned STEP_CYCLES = 1,
  parameter  int unsigned MODE_WIDTH  = 1,
  localparam int unsigned RW          = $clog2(ROUNDS + 1),
  localparam int unsigned SW          = $clog2(SIDE)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [MODE_WIDTH-1:0] mode_in,
  output logic [MODE_WIDTH-1:0] mode,
  output logic                  busy,
  output logic                  phase_row,
  output logic                  odd_step,
  output logic                  step_valid,
  output logic                  snake,
  output logic [RW-1:0]         round_idx,
  output logic [SW-1:0]         step_idx,
  output logic                  deliver,
  output logic                  done
);

  localparam int unsigned CW          = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [RW-1:0] LAST_ROUND = RW'(ROUNDS - 1);
  localparam logic          FIRST_SNAKE = 1'(ROUNDS > 1);

  state_e        state;
  logic          active_c;
  logic          cyc_last_c;
  logic          step_last_c;
  logic          phase_end_c;
  logic [CW-1:0] cyc_cnt;
  logic [RW-1:0] round_nxt_c;

  assign active_c    = (state == S_ROW) || (state == S_COL);
  assign phase_end_c = cyc_last_c && step_last_c;
  assign round_nxt_c = round_idx + RW'(1);
  assign odd_step    = step_idx[0];

  // Cycle within the current step
  mesh_step_cnt #(.MODULUS(STEP_CYCLES)) u_cyc_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr    (!active_c || abort),
    .en     (active_c),
    .count  (cyc_cnt),
    .last_c (cyc_last_c)
  );

  // Step within the current phase; its wrap coincides with the phase boundary
  mesh_step_cnt #(.MODULUS(SIDE)) u_step_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr    (!active_c || abort),
    .en     (active_c && cyc_last_c),
    .count  (step_idx),
    .last_c (step_last_c)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= S_IDLE;
      mode       <= '0;
      busy       <= 1'b0;
      phase_row  <= 1'b1;
      step_valid <= 1'b0;
      snake      <= 1'b0;
      round_idx  <= '0;
      deliver    <= 1'b0;
      done       <= 1'b0;
    end else begin
      step_valid <= 1'b0;
      deliver    <= 1'b0;
      done       <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start && !abort) begin
            state      <= S_ROW;
            mode       <= mode_in;
            busy       <= 1'b1;
            phase_row  <= 1'b1;
            round_idx  <= '0;
            snake      <= FIRST_SNAKE;
            step_valid <= 1'b1;
          end
        end
        S_ROW, S_COL: begin
          if (abort) begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            phase_row <= 1'b1;
            snake     <= 1'b0;
            round_idx <= '0;
          end else if (!phase_end_c) begin
            // Next cycle opens a new step once the cycle counter wraps
            step_valid <= (cyc_cnt == CW'(STEP_CYCLES - 1));
          end else if (state == S_COL) begin
            state      <= S_ROW;
            phase_row  <= 1'b1;
            round_idx  <= round_nxt_c;
            snake      <= (round_nxt_c < LAST_ROUND);
            step_valid <= 1'b1;
          end else if (round_idx == LAST_ROUND) begin
            state   <= S_DELIVER;
            snake   <= 1'b0;
            deliver <= 1'b1;
          end else begin
            state      <= S_COL;
            phase_row  <= 1'b0;
            snake      <= 1'b0;
            step_valid <= 1'b1;
          end
        end
        S_DELIVER: begin
          // Commit already issued to the PEs, so abort is not honoured here
          state <= S_DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        S_DONE: begin
          state     <= S_IDLE;
          round_idx <= '0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mesh_sort_sched.sv
// Directed bench for mesh_sort_sched: four instances with different geometries,
// a per-cycle expectation table plus hand-written abort/reset/ignored-start sequences.
module tb_mesh_sort_sched;
  import mesh_pkg::*;

  typedef struct {
    int busy;
    int prow;
    int odd;
    int sv;
    int snk;
    int rnd;
    int stp;
    int dlv;
    int dn;
    int full;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       start   [4];
  logic       abort   [4];
  logic [0:0] mode_in [4];
  logic [0:0] mode_o  [4];
  logic       busy_o  [4];
  logic       prow_o  [4];
  logic       odd_o   [4];
  logic       sv_o    [4];
  logic       snk_o   [4];
  logic       dlv_o   [4];
  logic       dn_o    [4];
  logic [1:0] ra, rb, sa, sb, sd;
  logic [2:0] rc;
  logic [3:0] sc;
  logic [0:0] rd;
  int         rnd [4];
  int         stp [4];

  int   checks = 0;
  int   errors = 0;
  vec_t tbl [15];

  always #5 clk = ~clk;

  always_comb begin
    rnd[0] = int'(ra); rnd[1] = int'(rb); rnd[2] = int'(rc); rnd[3] = int'(rd);
    stp[0] = int'(sa); stp[1] = int'(sb); stp[2] = int'(sc); stp[3] = int'(sd);
  end

  mesh_sort_sched #(.SIDE(4), .ROUNDS(2), .STEP_CYCLES(1)) u_a (
    .clk(clk), .rst(rst), .start(start[0]), .abort(abort[0]), .mode_in(mode_in[0]),
    .mode(mode_o[0]), .busy(busy_o[0]), .phase_row(prow_o[0]), .odd_step(odd_o[0]),
    .step_valid(sv_o[0]), .snake(snk_o[0]), .round_idx(ra), .step_idx(sa),
    .deliver(dlv_o[0]), .done(dn_o[0]));

  mesh_sort_sched #(.SIDE(4), .ROUNDS(2), .STEP_CYCLES(3)) u_b (
    .clk(clk), .rst(rst), .start(start[1]), .abort(abort[1]), .mode_in(mode_in[1]),
    .mode(mode_o[1]), .busy(busy_o[1]), .phase_row(prow_o[1]), .odd_step(odd_o[1]),
    .step_valid(sv_o[1]), .snake(snk_o[1]), .round_idx(rb), .step_idx(sb),
    .deliver(dlv_o[1]), .done(dn_o[1]));

  mesh_sort_sched #(.SIDE(16)) u_c (
    .clk(clk), .rst(rst), .start(start[2]), .abort(abort[2]), .mode_in(mode_in[2]),
    .mode(mode_o[2]), .busy(busy_o[2]), .phase_row(prow_o[2]), .odd_step(odd_o[2]),
    .step_valid(sv_o[2]), .snake(snk_o[2]), .round_idx(rc), .step_idx(sc),
    .deliver(dlv_o[2]), .done(dn_o[2]));

  mesh_sort_sched #(.SIDE(4), .ROUNDS(1), .STEP_CYCLES(1)) u_d (
    .clk(clk), .rst(rst), .start(start[3]), .abort(abort[3]), .mode_in(mode_in[3]),
    .mode(mode_o[3]), .busy(busy_o[3]), .phase_row(prow_o[3]), .odd_step(odd_o[3]),
    .step_valid(sv_o[3]), .snake(snk_o[3]), .round_idx(rd), .step_idx(sd),
    .deliver(dlv_o[3]), .done(dn_o[3]));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Pulse start for one cycle (cycle 0); returns positioned in cycle 1
  task automatic launch(input int i, input logic m);
    mode_in[i] = m;
    start[i]   = 1'b1;
    tick();
    start[i]   = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int dcyc;
    int ncyc;
    int cnt;
    int bad;
    int bad2;

    // Expected trace for SIDE=4, ROUNDS=2, STEP_CYCLES=1, cycles 1..15
    for (int p = 0; p < 3; p++) begin
      for (int s = 0; s < 4; s++) begin
        tbl[4*p+s] = '{1, int'(p != 1), s % 2, 1, int'(p == 0), int'(p == 2), s, 0, 0, 1};
      end
    end
    tbl[12] = '{1, 0, 0, 0, 0, 0, 0, 1, 0, 0};
    tbl[13] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
    tbl[14] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};

    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      start[i] = 1'b0; abort[i] = 1'b0; mode_in[i] = 1'b1;
    end
    repeat (3) tick();

    for (int i = 0; i < 4; i++) begin
      chk($sformatf("reset%0d busy", i), int'(busy_o[i]), 0);
      chk($sformatf("reset%0d phase_row", i), int'(prow_o[i]), 1);
      chk($sformatf("reset%0d mode", i), int'(mode_o[i]), 0);
      chk($sformatf("reset%0d step_valid", i), int'(sv_o[i]), 0);
      chk($sformatf("reset%0d snake", i), int'(snk_o[i]), 0);
      chk($sformatf("reset%0d odd", i), int'(odd_o[i]), 0);
      chk($sformatf("reset%0d round", i), rnd[i], 0);
      chk($sformatf("reset%0d step", i), stp[i], 0);
      chk($sformatf("reset%0d deliver", i), int'(dlv_o[i]), 0);
      chk($sformatf("reset%0d done", i), int'(dn_o[i]), 0);
    end
    rst = 1'b1;
    tick();

    // Table-driven trace of one full sort
    launch(0, 1'(MODE_WRITE));
    for (int k = 0; k < 15; k++) begin
      chk($sformatf("A c%0d busy", k+1), int'(busy_o[0]), tbl[k].busy);
      chk($sformatf("A c%0d step_valid", k+1), int'(sv_o[0]), tbl[k].sv);
      chk($sformatf("A c%0d deliver", k+1), int'(dlv_o[0]), tbl[k].dlv);
      chk($sformatf("A c%0d done", k+1), int'(dn_o[0]), tbl[k].dn);
      if (tbl[k].full != 0) begin
        chk($sformatf("A c%0d phase_row", k+1), int'(prow_o[0]), tbl[k].prow);
        chk($sformatf("A c%0d odd", k+1), int'(odd_o[0]), tbl[k].odd);
        chk($sformatf("A c%0d snake", k+1), int'(snk_o[0]), tbl[k].snk);
        chk($sformatf("A c%0d round", k+1), rnd[0], tbl[k].rnd);
        chk($sformatf("A c%0d step", k+1), stp[0], tbl[k].stp);
        chk($sformatf("A c%0d mode", k+1), int'(mode_o[0]), 0);
      end
      tick();
    end

    // STEP_CYCLES=3: pulse spacing, count and deliver latency
    launch(1, 1'(MODE_WRITE));
    cnt = 0; bad = 0; dcyc = -1; ncyc = -1;
    for (int c = 1; c <= 60; c++) begin
      if (sv_o[1]) begin
        cnt++;
        if ((c - 1) % 3 != 0) bad++;
      end
      if (dlv_o[1] && dcyc < 0) dcyc = c;
      if (dn_o[1] && ncyc < 0) ncyc = c;
      tick();
    end
    chk("B step_valid pulses", cnt, 12);
    chk("B misplaced step_valid", bad, 0);
    chk("B deliver cycle", dcyc, 1 + int'(sort_cycles(4, 2, 3)));
    chk("B done cycle", ncyc, 38);

    // SIDE=16 defaults, read mode held while busy
    launch(2, 1'(MODE_READ));
    cnt = 0; bad = 0; dcyc = -1; ncyc = -1;
    for (int c = 1; c <= 170; c++) begin
      if (busy_o[2]) begin
        cnt++;
        if (mode_o[2] != 1'b1) bad++;
      end
      if (dlv_o[2] && dcyc < 0) dcyc = c;
      if (dn_o[2] && ncyc < 0) ncyc = c;
      tick();
    end
    chk("C busy cycles", cnt, 145);
    chk("C mode not read while busy", bad, 0);
    chk("C deliver cycle", dcyc, 145);
    chk("C done cycle", ncyc, 146);

    // ROUNDS=1: single unsnaked row phase; abort on the deliver cycle is ignored
    launch(3, 1'(MODE_WRITE));
    bad = 0; bad2 = 0; dcyc = -1; ncyc = -1;
    for (int c = 1; c <= 12; c++) begin
      if (snk_o[3]) bad++;
      if (busy_o[3] && !prow_o[3]) bad2++;
      if (dlv_o[3] && dcyc < 0) dcyc = c;
      if (dn_o[3] && ncyc < 0) ncyc = c;
      abort[3] = (c == 5);
      tick();
    end
    abort[3] = 1'b0;
    chk("D snake seen", bad, 0);
    chk("D column phase seen", bad2, 0);
    chk("D deliver cycle", dcyc, 5);
    chk("D done after abort on deliver", ncyc, 6);

    // Abort during COL, then immediate restart
    launch(0, 1'(MODE_WRITE));
    dcyc = -1; ncyc = -1;
    for (int c = 1; c <= 30; c++) begin
      if (c == 6) chk("E c6 in column phase", int'(prow_o[0]), 0);
      if (c == 7) begin
        chk("E c7 busy", int'(busy_o[0]), 0);
        chk("E c7 phase_row", int'(prow_o[0]), 1);
        chk("E c7 step_valid", int'(sv_o[0]), 0);
        chk("E c7 step", stp[0], 0);
      end
      if (c == 8) begin
        chk("E c8 busy", int'(busy_o[0]), 1);
        chk("E c8 step_valid", int'(sv_o[0]), 1);
        chk("E c8 snake", int'(snk_o[0]), 1);
        chk("E c8 round", rnd[0], 0);
      end
      if (dlv_o[0] && dcyc < 0) dcyc = c;
      if (dn_o[0] && ncyc < 0) ncyc = c;
      abort[0] = (c == 6);
      start[0] = (c == 7);
      tick();
    end
    abort[0] = 1'b0; start[0] = 1'b0;
    chk("E deliver cycle", dcyc, 20);
    chk("E done cycle", ncyc, 21);

    // Reset mid-ROW, start while busy ignored
    launch(0, 1'(MODE_READ));
    cnt = 0;
    for (int c = 1; c <= 25; c++) begin
      if (c == 3) begin
        chk("F c3 step", stp[0], 2);
        chk("F c3 busy", int'(busy_o[0]), 1);
        chk("F c3 mode", int'(mode_o[0]), 1);
      end
      if (c == 4) begin
        chk("F c4 busy", int'(busy_o[0]), 0);
        chk("F c4 phase_row", int'(prow_o[0]), 1);
        chk("F c4 mode", int'(mode_o[0]), 0);
        chk("F c4 step", stp[0], 0);
        chk("F c4 odd", int'(odd_o[0]), 0);
        chk("F c4 step_valid", int'(sv_o[0]), 0);
        chk("F c4 snake", int'(snk_o[0]), 0);
      end
      if (dlv_o[0] || dn_o[0]) cnt++;
      start[0] = (c == 2);
      rst      = (c != 3);
      tick();
    end
    start[0] = 1'b0; rst = 1'b1;
    chk("F deliver/done after reset", cnt, 0);

    // Start during DONE ignored
    launch(0, 1'(MODE_WRITE));
    cnt = 0;
    for (int c = 1; c <= 20; c++) begin
      if (c == 14) chk("G c14 done", int'(dn_o[0]), 1);
      if (c >= 15 && busy_o[0]) cnt++;
      start[0] = (c == 14);
      tick();
    end
    start[0] = 1'b0;
    chk("G busy after start in DONE", cnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
